local_history_predictor: RTL and testbench
==========================================

// Module: local_history_predictor
// PURPOSE
//  Parametrised two-level local-history branch predictor; successor to the fixed 8-entry table.
//  Per-entry branch history register (BHT) selects one of 2^HIST_W saturating counters in that
//  entry's row (PHT). Registered lookup, forwarding update path, per-entry eviction, reset sweep.
//  Sits in fetch stage; update/evict driven from branch resolution in execute.
// PARAMETERS
//  PC_W      10  width of lookup_pc / upd_pc
//  IDX_W     3   entry index width; NUM_ENTRIES = 1<<IDX_W; IDX_W <= PC_W
//  HIST_W    3   local history bits per entry (>=2)
//  CTR_W     2   saturating counter width (>=2); prediction = counter MSB
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, active-low (rst==0 at edge resets)
//  ready        out  1       1 = init sweep done, lookups/updates/evicts accepted
//  lookup_valid in   1       request prediction for lookup_pc
//  lookup_pc    in   PC_W    fetch PC; entry = lookup_pc[IDX_W-1:0]
//  pred_valid   out  1       one-cycle pulse, 1 cycle after accepted lookup
//  pred_taken   out  1       prediction for that lookup
//  pred_hist    out  HIST_W  history used for that prediction; returned later on upd_hist
//  upd_valid    in   1       resolved branch update
//  upd_pc       in   PC_W    resolved branch PC; entry = upd_pc[IDX_W-1:0]
//  upd_taken    in   1       actual outcome
//  upd_hist     in   HIST_W  history the prediction was made with (selects counter)
//  evict_valid  in   1       clear one entry
//  evict_idx    in   IDX_W   entry to clear
// BEHAVIOUR
//  - Counter init value WNT = 2^(CTR_W-1)-1 (weakly not-taken); history init 0.
//  - FSM: INIT -> RUN. rst==0: state INIT, sweep ptr=0, ready=0, pred_valid=0, pred_taken=0,
//    pred_hist=0. INIT: each cycle clears entry[ptr] (history=0, whole row=WNT), ptr++;
//    after clearing entry NUM_ENTRIES-1 go RUN; ready=1 on cycle NUM_ENTRIES after rst rises.
//  - In INIT all lookup/upd/evict inputs ignored; pred_valid stays 0.
//  - rst==0 during INIT or RUN restarts sweep from ptr 0; in-flight prediction discarded.
//  - Lookup (RUN, lookup_valid): next edge pred_valid=1, pred_hist=H[i],
//    pred_taken=PHT[i][H[i]][CTR_W-1], values read from NEXT-state of this same cycle
//    (i.e. after same-cycle update/evict applied). pred_taken/pred_hist hold when pred_valid=0.
//  - Update (RUN, upd_valid), entry u: PHT[u][upd_hist] += 1 if taken, -= 1 if not;
//    saturate at 0 and 2^CTR_W-1 (no wrap). H[u] <= {H[u][HIST_W-2:0], upd_taken}.
//  - Evict (RUN, evict_valid), entry e: H[e]=0, row e = all WNT.
//  - evict and update same entry same cycle: evict wins, update dropped entirely.
//    Different entries: both apply.
//  - Index aliasing: PCs equal in low IDX_W bits share an entry; no tags.
//  - Storage is registers (no RAM); single-cycle read/modify/write, no stalls, no backpressure.
// TESTING (IDX_W=3, HIST_W=3, CTR_W=2, WNT=1)
//  1 Reset: rst=0 2 cycles, release -> ready=0 for 8 cycles, ready=1 on 8th; lookup pc=0x005
//    -> next cycle pred_valid=1, pred_taken=0, pred_hist=3'b000.
//  2 Training: pc=0x003 updates taken with upd_hist 000,001,011,111,111 -> lookup pc=0x003
//    gives pred_hist=3'b111, pred_taken=1; lookup pc=0x00B (alias) gives identical result.
//  3 Saturation: 3 more taken updates at hist 111 -> counter 3 (no wrap to 0); one not-taken
//    -> counter 2, still taken; 5 not-taken at fresh hist 010 -> counter stays 0.
//  4 Forwarding: same cycle lookup pc=0x002 and upd pc=0x002 taken hist 000 (entry fresh)
//    -> pred_hist=3'b001, pred_taken=0 (counter[001]=1; counter[000]=2 not used).
//  5 Collision: after test 2, same cycle evict_idx=3 and upd pc=0x003 taken, plus lookup
//    pc=0x003 -> pred_hist=000, pred_taken=0; next lookup identical (update dropped).
//  6 Reset mid-sweep: rst=0 at sweep cycle 4 -> ready stays 0, rises 8 cycles after release;
//    lookups during INIT produce no pred_valid.

Source files
------------

// File: rtl/local_history_predictor_if.sv
// Lookup, prediction, update and evict signals of the local-history predictor.
// The master drives requests. The slave (the predictor) returns ready and predictions.
interface local_history_predictor_if #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned HIST_W = 3
) ();
    logic              ready;
    logic              lookup_valid;
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [HIST_W-1:0] upd_hist;
    logic              evict_valid;
    logic [IDX_W-1:0]  evict_idx;

    modport master (
        input  ready, pred_valid, pred_taken, pred_hist,
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_hist,
        output evict_valid, evict_idx
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_hist,
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_hist,
        input  evict_valid, evict_idx
    );
endinterface

// File: rtl/local_history_predictor.sv
// Two-level local-history branch predictor. Each entry's history selects a saturating counter
// in that entry's row. Lookups read the same-cycle post-update state.
module local_history_predictor #(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned HIST_W = 3,
    parameter int unsigned CTR_W  = 2
) (
    input logic                        i_clk,
    input logic                        i_rst,
    local_history_predictor_if.slave   io_bus
);
    localparam int unsigned NUM_ENTRIES = 1 << IDX_W;
    localparam int unsigned NUM_CTRS    = 1 << HIST_W;
    localparam logic [CTR_W-1:0] WNT    = {1'b0, {(CTR_W-1){1'b1}}};

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             r_state, w_state_d;
    logic [IDX_W-1:0]   r_ptr, w_ptr_d;
    logic               r_pred_valid, w_pred_valid_d;
    logic               r_pred_taken, w_pred_taken_d;
    logic [HIST_W-1:0]  r_pred_hist, w_pred_hist_d;

    logic [HIST_W-1:0]  r_hist [NUM_ENTRIES];
    logic [HIST_W-1:0]  w_hist_d [NUM_ENTRIES];
    logic [CTR_W-1:0]   r_pht [NUM_ENTRIES][NUM_CTRS];
    logic [CTR_W-1:0]   w_pht_d [NUM_ENTRIES][NUM_CTRS];

    logic [IDX_W-1:0]   w_upd_idx;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [CTR_W-1:0]   w_ctr;
    logic               w_upd_en;

    assign w_upd_idx = io_bus.upd_pc[IDX_W-1:0];
    assign w_lk_idx  = io_bus.lookup_pc[IDX_W-1:0];
    // An evict of the same entry drops the whole update, history shift included.
    assign w_upd_en  = io_bus.upd_valid &&
                       !(io_bus.evict_valid && (io_bus.evict_idx == w_upd_idx));

    always_comb begin
        w_state_d      = r_state;
        w_ptr_d        = r_ptr;
        w_pred_valid_d = 1'b0;
        w_pred_taken_d = r_pred_taken;
        w_pred_hist_d  = r_pred_hist;
        w_hist_d       = r_hist;
        w_pht_d        = r_pht;
        w_ctr          = '0;

        unique case (r_state)
            StInit: begin
                w_hist_d[r_ptr] = '0;
                for (int j = 0; j < NUM_CTRS; j++) begin
                    w_pht_d[r_ptr][j] = WNT;
                end
                w_ptr_d = r_ptr + IDX_W'(1);
                if (r_ptr == {IDX_W{1'b1}}) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (w_upd_en) begin
                    w_ctr = r_pht[w_upd_idx][io_bus.upd_hist];
                    if (io_bus.upd_taken && (w_ctr != {CTR_W{1'b1}})) begin
                        w_ctr = w_ctr + CTR_W'(1);
                    end else if (!io_bus.upd_taken && (w_ctr != '0)) begin
                        w_ctr = w_ctr - CTR_W'(1);
                    end
                    w_pht_d[w_upd_idx][io_bus.upd_hist] = w_ctr;
                    w_hist_d[w_upd_idx] = {r_hist[w_upd_idx][HIST_W-2:0], io_bus.upd_taken};
                end
                if (io_bus.evict_valid) begin
                    w_hist_d[io_bus.evict_idx] = '0;
                    for (int j = 0; j < NUM_CTRS; j++) begin
                        w_pht_d[io_bus.evict_idx][j] = WNT;
                    end
                end
                // Read from next-state so same-cycle update/evict are forwarded.
                if (io_bus.lookup_valid) begin
                    w_pred_valid_d = 1'b1;
                    w_pred_hist_d  = w_hist_d[w_lk_idx];
                    w_pred_taken_d = w_pht_d[w_lk_idx][w_hist_d[w_lk_idx]][CTR_W-1];
                end
            end
            default: begin
                w_state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= StInit;
            r_ptr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_hist  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_ptr        <= w_ptr_d;
            r_pred_valid <= w_pred_valid_d;
            r_pred_taken <= w_pred_taken_d;
            r_pred_hist  <= w_pred_hist_d;
        end
    end

    // Tables need no reset value; the init sweep overwrites every entry before use.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= w_hist_d;
            r_pht  <= w_pht_d;
        end
    end

    assign io_bus.ready      = (r_state == StRun);
    assign io_bus.pred_valid = r_pred_valid;
    assign io_bus.pred_taken = r_pred_taken;
    assign io_bus.pred_hist  = r_pred_hist;
endmodule

// File: tb/tb_local_history_predictor.sv
// Randomised and directed bench for local_history_predictor. A scoreboard queue receives
// the expected predictions, and a monitor pops and compares each one.
module tb_local_history_predictor;
    logic clk;
    logic rst;

    local_history_predictor_if #(.PC_W(10), .IDX_W(3), .HIST_W(3)) bus ();

    local_history_predictor #(.PC_W(10), .IDX_W(3), .HIST_W(3), .CTR_W(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       t;
        bit [2:0] h;
        int       due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: plain integers, counters clamp to [0,3].
    int   m_hist [8];
    int   m_ctr  [8][8];
    bit   m_ready = 0;
    int   m_sweep = 0;

    bit       ovr = 0;
    bit       ovr_t;
    bit [2:0] ovr_h;

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_hist[i] = 0;
            for (int j = 0; j < 8; j++) m_ctr[i][j] = 1;
        end
    endfunction

    task automatic tick();
        exp_t e;
        int   u, ev, l;
        if (rst && m_ready) begin
            u  = int'(bus.upd_pc[2:0]);
            ev = int'(bus.evict_idx);
            if (bus.upd_valid && !(bus.evict_valid && ev == u)) begin
                if (bus.upd_taken) m_ctr[u][bus.upd_hist] = (m_ctr[u][bus.upd_hist] < 3) ?
                                                            m_ctr[u][bus.upd_hist] + 1 : 3;
                else               m_ctr[u][bus.upd_hist] = (m_ctr[u][bus.upd_hist] > 0) ?
                                                            m_ctr[u][bus.upd_hist] - 1 : 0;
                m_hist[u] = (m_hist[u] * 2 + int'(bus.upd_taken)) % 8;
            end
            if (bus.evict_valid) begin
                m_hist[ev] = 0;
                for (int j = 0; j < 8; j++) m_ctr[ev][j] = 1;
            end
            if (bus.lookup_valid) begin
                l = int'(bus.lookup_pc[2:0]);
                e.due = cyc + 1;
                if (ovr) begin
                    e.t = ovr_t;
                    e.h = ovr_h;
                end else begin
                    e.t = (m_ctr[l][m_hist[l]] >= 2);
                    e.h = 3'(m_hist[l]);
                end
                q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_ready = 0;
            m_sweep = 0;
            model_clear();
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == 8) m_ready = 1;
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== m_ready) begin
            failures++;
            $display("FAIL ready cyc=%0d got=%0b exp=%0b", cyc, bus.ready, m_ready);
        end
        if (!rst) begin
            checks++;
            if (bus.pred_valid !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_hist !== 3'b000) begin
                failures++;
                $display("FAIL reset_outputs got v=%0b t=%0b h=%03b exp v=0 t=0 h=000",
                         bus.pred_valid, bus.pred_taken, bus.pred_hist);
            end
        end
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.evict_valid  = 1'b0;
        ovr              = 0;
    endtask

    task automatic do_upd(input bit [9:0] pc, input bit t, input bit [2:0] h);
        bus.upd_valid = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = t;
        bus.upd_hist  = h;
    endtask

    task automatic do_lookup(input bit [9:0] pc, input bit use_const, input bit t,
                             input bit [2:0] h);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        ovr              = use_const;
        ovr_t            = t;
        ovr_h            = h;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL pred_missing due=%0d now=%0d got=none exp=t%0b/h%03b",
                     q[0].due, cyc, q[0].t, q[0].h);
            void'(q.pop_front());
        end
        if (bus.pred_valid) begin
            checks++;
            if (q.size() == 0 || q[0].due != cyc) begin
                failures++;
                $display("FAIL pred_unexpected cyc=%0d got=pred_valid exp=none", cyc);
            end else begin
                e = q.pop_front();
                if (bus.pred_taken !== e.t || bus.pred_hist !== e.h) begin
                    failures++;
                    $display("FAIL pred cyc=%0d got t=%0b h=%03b exp t=%0b h=%03b",
                             cyc, bus.pred_taken, bus.pred_hist, e.t, e.h);
                end
            end
        end
    end

    initial begin
        rst              = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_taken    = 1'b0;
        bus.upd_hist     = '0;
        bus.evict_valid  = 1'b0;
        bus.evict_idx    = '0;
        model_clear();
        @(negedge clk);

        // Reset and init sweep
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        do_lookup(10'h005, 1, 1'b0, 3'b000); tick();

        // Training and aliasing
        do_upd(10'h003, 1, 3'b000); tick();
        do_upd(10'h003, 1, 3'b001); tick();
        do_upd(10'h003, 1, 3'b011); tick();
        do_upd(10'h003, 1, 3'b111); tick();
        do_upd(10'h003, 1, 3'b111); tick();
        do_lookup(10'h003, 1, 1'b1, 3'b111); tick();
        do_lookup(10'h00B, 1, 1'b1, 3'b111); tick();

        // Saturation high: 3->3, then one not-taken gives 2 (still taken)
        for (int i = 0; i < 3; i++) begin do_upd(10'h003, 1, 3'b111); tick(); end
        do_lookup(10'h003, 1, 1'b1, 3'b111); tick();
        do_upd(10'h003, 0, 3'b111); tick();
        for (int i = 0; i < 3; i++) begin do_upd(10'h003, 1, 3'b000); tick(); end
        do_lookup(10'h003, 1, 1'b1, 3'b111); tick();

        // Saturation low on fresh entry 4: stays 0, one taken gives 1
        for (int i = 0; i < 5; i++) begin do_upd(10'h004, 0, 3'b010); tick(); end
        do_upd(10'h004, 1, 3'b010); tick();
        do_upd(10'h004, 0, 3'b101); tick();
        do_lookup(10'h004, 1, 1'b0, 3'b010); tick();

        // Forwarding of same-cycle update
        do_upd(10'h002, 1, 3'b000);
        do_lookup(10'h002, 1, 1'b0, 3'b001); tick();

        // Evict beats update on same entry
        do_upd(10'h003, 1, 3'b111);
        bus.evict_valid = 1'b1;
        bus.evict_idx   = 3'd3;
        do_lookup(10'h003, 1, 1'b0, 3'b000); tick();
        do_lookup(10'h003, 1, 1'b0, 3'b000); tick();

        // Evict and update on different entries both apply
        do_upd(10'h001, 1, 3'b000);
        bus.evict_valid = 1'b1;
        bus.evict_idx   = 3'd4;
        do_lookup(10'h001, 1, 1'b0, 3'b001); tick();
        do_lookup(10'h004, 1, 1'b0, 3'b000); tick();

        // Reset mid-sweep; lookups during init must stay silent
        rst = 1'b0; tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin do_lookup(10'($urandom), 0, 0, 0); tick(); end
        rst = 1'b0; do_lookup(10'h001, 0, 0, 0); tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin do_lookup(10'($urandom), 0, 0, 0); tick(); end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 1) do_lookup(10'($urandom), 0, 0, 0);
            if ($urandom_range(0, 1) == 1)
                do_upd(10'($urandom), 1'($urandom), 3'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                bus.evict_valid = 1'b1;
                bus.evict_idx   = ($urandom_range(0, 1) == 1) ? bus.upd_pc[2:0] : 3'($urandom);
            end
            tick();
        end

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
